// File: rtl/data_mem_if.sv
// Request/response bus between the ALU-side master and the data memory stage.
//   req   : access request (master -> slave)
//   we    : 1 = store, 0 = load
//   addr  : byte address
//   wdata : store data
//   rdata : load result (slave -> master)
//   ready : one-cycle completion pulse
//   busy  : access in flight
//   err   : qualifies ready, address fault
interface data_mem_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        err;

  modport master (output req, we, addr, wdata,
                  input  rdata, ready, busy, err);
  modport slave  (input  req, we, addr, wdata,
                  output rdata, ready, busy, err);
endinterface

// File: rtl/data_mem_ctrl.sv
// Multi-cycle data memory stage sitting after the ALU.
// Accepts a word load/store in IDLE, waits LATENCY cycles, then performs the
// access and pulses ready. Misaligned or out-of-range addresses skip the
// access and complete with err=1.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset (memory contents are not cleared)
//   bus   : data_mem_if slave port (req/we/addr/wdata in, rdata/ready/busy/err out)
//
// state | meaning
// IDLE  | waiting for req
// WAIT  | counting down latency before the access
// FAULT | address fault, access skipped
// DONE  | completion cycle, ready asserted
module data_mem_ctrl #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  data_mem_if.slave   bus
);

  localparam int          IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_L = DEPTH_WORDS;
  localparam logic [3:0]  LAT4    = LATENCY[3:0];

  typedef enum logic [1:0] {IDLE, WAIT, FAULT, DONE} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               mem_we;
  logic               addr_fault;

  logic [31:0] mem [DEPTH_WORDS];

  // Full 30-bit word index compare so large addresses never alias into range.
  assign addr_fault = (bus.addr[1:0] != 2'b00) ||
                      ({2'b00, bus.addr[31:2]} >= DEPTH_L);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          idx_d   = bus.addr[IDX_W+1:2];
          wdata_d = bus.wdata;
          cnt_d   = LAT4;
          state_d = addr_fault ? FAULT : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = DONE;
          if (we_q) mem_we  = 1'b1;
          else      rdata_d = mem[idx_q];
        end
      end
      FAULT: begin
        state_d = DONE;
        rdata_d = 32'd0;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == DONE);
    err_d   = (state_d == DONE) && (state_q == FAULT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // Gated by rst_n so a reset landing on the access edge discards the store.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem[idx_q] <= wdata_q;
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  logic [31:0] mem_m [int unsigned];
  int unsigned written [$];
  logic [31:0] model_rd;

  data_mem_if ifc ();
  data_mem_if ifc0 ();

  data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc.slave));
  data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(ifc0.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one access on the LATENCY=2 instance; returns edges to ready (-1 on
  // timeout), sampled rdata/err, number of busy samples and the state one
  // cycle after ready.
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd, output logic e,
                        output int bc, output logic rdy_after, output logic busy_after);
    @(negedge clk);
    ifc.req = 1'b1; ifc.we = w; ifc.addr = a; ifc.wdata = d;
    @(posedge clk); #1;
    ifc.req = 1'b0; ifc.we = ~w; ifc.addr = $urandom; ifc.wdata = $urandom;
    bc = ifc.busy ? 1 : 0;
    lat = -1; rd = 32'hx; e = 1'bx;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (ifc.busy) bc++;
      if (ifc.ready) begin
        lat = i; rd = ifc.rdata; e = ifc.err;
        break;
      end
    end
    @(posedge clk); #1;
    rdy_after = ifc.ready; busy_after = ifc.busy;
  endtask

  task automatic access0(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] rd, output logic e);
    @(negedge clk);
    ifc0.req = 1'b1; ifc0.we = w; ifc0.addr = a; ifc0.wdata = d;
    @(posedge clk); #1;
    ifc0.req = 1'b0; ifc0.addr = $urandom; ifc0.wdata = $urandom;
    lat = -1; rd = 32'hx; e = 1'bx;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (ifc0.ready) begin
        lat = i; rd = ifc0.rdata; e = ifc0.err;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifc.req = 1'b1; ifc.we = 1'b1; ifc.addr = 32'h10; ifc.wdata = 32'h0BAD0BAD;
    ifc0.req = 1'b0; ifc0.we = 1'b0; ifc0.addr = 32'h0; ifc0.wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (ifc.rdata !== 32'd0) $display("FAIL reset_rdata got=%h exp=0", ifc.rdata); else n_pass++;
    n_total++; if (ifc.ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", ifc.ready); else n_pass++;
    n_total++; if (ifc.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", ifc.busy); else n_pass++;
    n_total++; if (ifc.err !== 1'b0) $display("FAIL reset_err got=%b exp=0", ifc.err); else n_pass++;
    @(negedge clk);
    ifc.req = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    n_total++; if (ifc.busy !== 1'b0) $display("FAIL reset_no_access busy=%b exp=0", ifc.busy); else n_pass++;
    model_rd = 32'd0;
  endtask

  task automatic test_store_load();
    int lat, bc; logic [31:0] rd; logic e, ra, ba;
    access(1'b1, 32'h10, 32'hDEADBEEF, lat, rd, e, bc, ra, ba);
    mem_m[4] = 32'hDEADBEEF; written.push_back(4);
    n_total++; if (lat !== LAT + 1) $display("FAIL sw_latency got=%0d exp=%0d", lat, LAT + 1); else n_pass++;
    n_total++; if (bc !== LAT + 2) $display("FAIL sw_busy_cycles got=%0d exp=%0d", bc, LAT + 2); else n_pass++;
    n_total++; if (e !== 1'b0) $display("FAIL sw_err got=%b exp=0", e); else n_pass++;
    n_total++; if (rd !== model_rd) $display("FAIL sw_rdata_held got=%h exp=%h", rd, model_rd); else n_pass++;
    n_total++; if (ra !== 1'b0 || ba !== 1'b0) $display("FAIL sw_single_pulse ready=%b busy=%b exp=0/0", ra, ba); else n_pass++;
    access(1'b0, 32'h10, 32'h0, lat, rd, e, bc, ra, ba);
    model_rd = 32'hDEADBEEF;
    n_total++; if (lat !== LAT + 1) $display("FAIL lw_latency got=%0d exp=%0d", lat, LAT + 1); else n_pass++;
    n_total++; if (rd !== 32'hDEADBEEF) $display("FAIL lw_rdata got=%h exp=deadbeef", rd); else n_pass++;
    n_total++; if (e !== 1'b0) $display("FAIL lw_err got=%b exp=0", e); else n_pass++;
  endtask

  task automatic test_faults();
    int lat, bc; logic [31:0] rd; logic e, ra, ba;
    access(1'b0, 32'h13, 32'h0, lat, rd, e, bc, ra, ba);
    model_rd = 32'd0;
    n_total++; if (lat !== 1) $display("FAIL misalign_latency got=%0d exp=1", lat); else n_pass++;
    n_total++; if (e !== 1'b1) $display("FAIL misalign_err got=%b exp=1", e); else n_pass++;
    n_total++; if (rd !== 32'd0) $display("FAIL misalign_rdata got=%h exp=0", rd); else n_pass++;
    n_total++; if (ra !== 1'b0 || ba !== 1'b0) $display("FAIL fault_single_pulse ready=%b busy=%b exp=0/0", ra, ba); else n_pass++;
    access(1'b1, 32'h0, 32'h11112222, lat, rd, e, bc, ra, ba);
    mem_m[0] = 32'h11112222; written.push_back(0);
    access(1'b1, 32'h3FC, 32'h3333FFFF, lat, rd, e, bc, ra, ba);
    mem_m[255] = 32'h3333FFFF; written.push_back(255);
    access(1'b1, 32'h400, 32'h55555555, lat, rd, e, bc, ra, ba);
    n_total++; if (e !== 1'b1 || lat !== 1) $display("FAIL range_fault err=%b lat=%0d exp=1/1", e, lat); else n_pass++;
    access(1'b0, 32'h0, 32'h0, lat, rd, e, bc, ra, ba);
    model_rd = mem_m[0];
    n_total++; if (rd !== 32'h11112222) $display("FAIL no_alias_word0 got=%h exp=11112222", rd); else n_pass++;
    access(1'b0, 32'h3FC, 32'h0, lat, rd, e, bc, ra, ba);
    model_rd = mem_m[255];
    n_total++; if (e !== 1'b0 || lat !== LAT + 1) $display("FAIL last_word err=%b lat=%0d exp=0/%0d", e, lat, LAT + 1); else n_pass++;
    n_total++; if (rd !== 32'h3333FFFF) $display("FAIL last_word_rdata got=%h exp=3333ffff", rd); else n_pass++;
  endtask

  task automatic test_busy_req();
    int lat, bc, pulses; logic [31:0] rd, seen; logic e, ra, ba;
    pulses = 0; seen = 32'hx;
    @(negedge clk);
    ifc.req = 1'b1; ifc.we = 1'b0; ifc.addr = 32'h10; ifc.wdata = 32'h0;
    @(posedge clk); #1;
    ifc.we = 1'b1; ifc.addr = 32'h3FC; ifc.wdata = 32'hBADBAD00;
    for (int i = 1; i <= LAT + 2; i++) begin
      @(posedge clk); #1;
      if (ifc.ready) begin pulses++; seen = ifc.rdata; end
    end
    ifc.req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ifc.ready) pulses++;
    end
    model_rd = mem_m[4];
    n_total++; if (pulses !== 1) $display("FAIL busy_req_pulses got=%0d exp=1", pulses); else n_pass++;
    n_total++; if (seen !== mem_m[4]) $display("FAIL busy_req_rdata got=%h exp=%h", seen, mem_m[4]); else n_pass++;
    n_total++; if (ifc.busy !== 1'b0) $display("FAIL busy_req_idle busy=%b exp=0", ifc.busy); else n_pass++;
    access(1'b0, 32'h3FC, 32'h0, lat, rd, e, bc, ra, ba);
    model_rd = mem_m[255];
    n_total++; if (rd !== mem_m[255]) $display("FAIL busy_req_mem_untouched got=%h exp=%h", rd, mem_m[255]); else n_pass++;
  endtask

  task automatic test_reset_mid(input int k);
    int lat, bc; logic [31:0] rd; logic e, ra, ba;
    access(1'b1, 32'h20, 32'hCAFEF00D, lat, rd, e, bc, ra, ba);
    mem_m[8] = 32'hCAFEF00D; written.push_back(8);
    @(negedge clk);
    ifc.req = 1'b1; ifc.we = 1'b1; ifc.addr = 32'h20; ifc.wdata = 32'h12345678;
    @(posedge clk); #1;
    ifc.req = 1'b0;
    repeat (k - 1) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    model_rd = 32'd0;
    n_total++; if (ifc.busy !== 1'b0 || ifc.ready !== 1'b0 || ifc.rdata !== 32'd0)
      $display("FAIL reset_mid_outputs k=%0d busy=%b ready=%b rdata=%h exp=0/0/0", k, ifc.busy, ifc.ready, ifc.rdata);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    access(1'b0, 32'h20, 32'h0, lat, rd, e, bc, ra, ba);
    model_rd = mem_m[8];
    n_total++; if (rd !== 32'hCAFEF00D) $display("FAIL reset_mid_store_dropped k=%0d got=%h exp=cafef00d", k, rd); else n_pass++;
  endtask

  task automatic test_random();
    int lat, bc, r; logic [31:0] rd, a, d, exp_rd; logic e, ra, ba, w, exp_e;
    int unsigned idx;
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      d = $urandom;
      if (r < 3) begin
        idx = $urandom_range(0, DEPTH - 1); a = idx << 2; w = 1'b1; exp_e = 1'b0;
      end else if (r < 7) begin
        idx = written[$urandom_range(0, written.size() - 1)]; a = idx << 2; w = 1'b0; exp_e = 1'b0;
      end else begin
        w = 1'($urandom_range(0, 1)); exp_e = 1'b1; idx = 0;
        if ($urandom_range(0, 1) == 1) a = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
        else a = (32'(DEPTH) * 4 + 32'($urandom) % 32'h3FFF_0000) & 32'hFFFF_FFFC;
      end
      access(w, a, d, lat, rd, e, bc, ra, ba);
      if (exp_e) model_rd = 32'd0;
      else if (w) begin
        if (!mem_m.exists(idx)) written.push_back(idx);
        mem_m[idx] = d;
      end else model_rd = mem_m[idx];
      exp_rd = model_rd;
      n_total++; if (lat !== (exp_e ? 1 : LAT + 1)) $display("FAIL rand_latency n=%0d addr=%h got=%0d exp=%0d", n, a, lat, exp_e ? 1 : LAT + 1); else n_pass++;
      n_total++; if (e !== exp_e) $display("FAIL rand_err n=%0d addr=%h got=%b exp=%b", n, a, e, exp_e); else n_pass++;
      n_total++; if (rd !== exp_rd) $display("FAIL rand_rdata n=%0d addr=%h got=%h exp=%h", n, a, rd, exp_rd); else n_pass++;
    end
  endtask

  task automatic test_latency0();
    int lat; logic [31:0] rd; logic e;
    int edges [$];
    logic data_ok;
    access0(1'b1, 32'h0, 32'h00000001, lat, rd, e);
    n_total++; if (lat !== 1 || e !== 1'b0) $display("FAIL lat0_sw lat=%0d err=%b exp=1/0", lat, e); else n_pass++;
    access0(1'b0, 32'h0, 32'h0, lat, rd, e);
    n_total++; if (lat !== 1) $display("FAIL lat0_lw_latency got=%0d exp=1", lat); else n_pass++;
    n_total++; if (rd !== 32'h00000001) $display("FAIL lat0_lw_rdata got=%h exp=00000001", rd); else n_pass++;
    data_ok = 1'b1;
    @(negedge clk);
    ifc0.req = 1'b1; ifc0.we = 1'b0; ifc0.addr = 32'h0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (ifc0.ready) begin
        edges.push_back(k);
        if (ifc0.rdata !== 32'h00000001) data_ok = 1'b0;
      end
    end
    ifc0.req = 1'b0;
    n_total++;
    if (edges.size() !== 4) $display("FAIL lat0_b2b_count got=%0d exp=4", edges.size());
    else if (edges[0] !== 2 || edges[1] !== 5 || edges[2] !== 8 || edges[3] !== 11)
      $display("FAIL lat0_b2b_spacing got=%0d,%0d,%0d,%0d exp=2,5,8,11", edges[0], edges[1], edges[2], edges[3]);
    else n_pass++;
    n_total++; if (data_ok !== 1'b1) $display("FAIL lat0_b2b_rdata got=bad exp=00000001"); else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (ifc0.busy !== 1'b0) $display("FAIL lat0_idle busy=%b exp=0", ifc0.busy); else n_pass++;
  endtask

  initial begin
    n_pass = 0; n_total = 0; model_rd = 32'd0;
    test_reset();
    test_store_load();
    test_faults();
    test_busy_req();
    test_reset_mid(1);
    test_reset_mid(LAT + 1);
    test_random();
    test_latency0();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
